// File: rtl/facto_job_scheduler.sv
// Round-robin scheduler sharing one FactoCore slave between two requesters: programs the
// core over its register bus, collects the 128-bit factorial and returns it on a rsp channel.
module facto_job_scheduler #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    input  logic [127:0] req_operand,
    output logic [1:0]   req_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_result,
    output logic         rsp_err,
    output logic         busy,
    output logic         m_sel,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_dout,
    input  logic [63:0]  m_din,
    input  logic         interrupt
);
    // state    | meaning
    // IDLE     | arbitrate; on grant issue the operand write
    // W_OPND   | operand write on bus
    // W_IEN    | intrEn = 1 write on bus
    // W_START  | opstart = 1 write on bus
    // WAIT_IRQ | wait for interrupt or timeout
    // RD_H     | read result_h on bus
    // CAP_H    | capture result_h from m_din
    // RD_L     | read result_l on bus
    // CAP_L    | capture result_l from m_din
    // W_CLR1   | opclear = 1 write on bus
    // W_CLR0   | opclear = 0 write on bus
    // RESP     | hold response until rsp_ready
    typedef enum logic [3:0] {
        IDLE, W_OPND, W_IEN, W_START, WAIT_IRQ, RD_H, CAP_H, RD_L, CAP_L, W_CLR1, W_CLR0, RESP
    } state_t;

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] OFF_OPSTART  = 3'd0;
    localparam logic [2:0] OFF_OPCLEAR  = 3'd1;
    localparam logic [2:0] OFF_INTREN   = 3'd3;
    localparam logic [2:0] OFF_OPERAND  = 3'd4;
    localparam logic [2:0] OFF_RESULT_H = 3'd5;
    localparam logic [2:0] OFF_RESULT_L = 3'd6;

    function automatic logic [15:0] reg_addr(input logic [2:0] off);
        return BASE_ADDR + {10'd0, off, 3'b000};
    endfunction

    state_t        state;
    logic          last_grant;
    logic          job_id;
    logic          job_err;
    logic          grant;
    logic [63:0]   result_h;
    logic [63:0]   result_l;
    logic [TW-1:0] tcnt;

    // Alternate when both request, otherwise serve whichever one is asking.
    assign grant = (&req_valid) ? ~last_grant : req_valid[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            job_id     <= 1'b0;
            job_err    <= 1'b0;
            result_h   <= '0;
            result_l   <= '0;
            tcnt       <= '0;
            req_ready  <= 2'b00;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            m_sel      <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_dout     <= '0;
        end else begin
            req_ready <= 2'b00;
            m_sel     <= 1'b0;
            m_wr      <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready  <= grant ? 2'b10 : 2'b01;
                        job_id     <= grant;
                        last_grant <= grant;
                        job_err    <= 1'b0;
                        result_h   <= '0;
                        result_l   <= '0;
                        busy       <= 1'b1;
                        m_sel      <= 1'b1;
                        m_wr       <= 1'b1;
                        m_addr     <= reg_addr(OFF_OPERAND);
                        m_dout     <= grant ? req_operand[127:64] : req_operand[63:0];
                        state      <= W_OPND;
                    end
                end
                W_OPND: begin
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= reg_addr(OFF_INTREN);
                    m_dout <= 64'd1;
                    state  <= W_IEN;
                end
                W_IEN: begin
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= reg_addr(OFF_OPSTART);
                    m_dout <= 64'd1;
                    state  <= W_START;
                end
                W_START: begin
                    tcnt  <= '0;
                    state <= WAIT_IRQ;
                end
                WAIT_IRQ: begin
                    if (interrupt) begin
                        m_sel  <= 1'b1;
                        m_addr <= reg_addr(OFF_RESULT_H);
                        state  <= RD_H;
                    end else if (tcnt == TCNT_LAST) begin
                        // Abort: still clear the core so the next job starts clean.
                        job_err <= 1'b1;
                        m_sel   <= 1'b1;
                        m_wr    <= 1'b1;
                        m_addr  <= reg_addr(OFF_OPCLEAR);
                        m_dout  <= 64'd1;
                        state   <= W_CLR1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RD_H: state <= CAP_H;
                CAP_H: begin
                    result_h <= m_din;
                    m_sel    <= 1'b1;
                    m_addr   <= reg_addr(OFF_RESULT_L);
                    state    <= RD_L;
                end
                RD_L: state <= CAP_L;
                CAP_L: begin
                    result_l <= m_din;
                    m_sel    <= 1'b1;
                    m_wr     <= 1'b1;
                    m_addr   <= reg_addr(OFF_OPCLEAR);
                    m_dout   <= 64'd1;
                    state    <= W_CLR1;
                end
                W_CLR1: begin
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= reg_addr(OFF_OPCLEAR);
                    m_dout <= 64'd0;
                    state  <= W_CLR0;
                end
                W_CLR0: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= job_id;
                    rsp_result <= job_err ? 128'd0 : {result_h, result_l};
                    rsp_err    <= job_err;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_id     <= 1'b0;
                        rsp_result <= '0;
                        rsp_err    <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_facto_job_scheduler.sv
// Bench for facto_job_scheduler: behavioural FactoCore slave, transaction-level reference
// model compared every cycle, directed literal scenarios and a randomized job phase.
module tb_facto_job_scheduler;
    localparam int T     = 16;
    localparam int NEVER = 1000000;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } bus_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [127:0] req_operand = '0;
    logic [1:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [127:0] rsp_result;
    logic         rsp_err;
    logic         busy;
    logic         m_sel;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [63:0]  m_dout;
    logic [63:0]  m_din;
    logic         interrupt;

    facto_job_scheduler #(.BASE_ADDR(16'h0000), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_operand(req_operand),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy), .m_sel(m_sel), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    // FactoCore stand-in: registered read data, interrupt = intrEn[0] & opdone.
    int          cur_delay = 0;
    logic [63:0] s_operand, s_ien, s_rh, s_rl;
    logic        s_done, s_run;
    int          s_cnt;

    always @(posedge clk) begin
        if (!reset_n) begin
            s_operand <= '0; s_ien <= '0; s_rh <= '0; s_rl <= '0;
            s_done <= 1'b0; s_run <= 1'b0; s_cnt <= 0; m_din <= '0;
        end else begin
            if (s_run) begin
                if (s_cnt <= 1) begin
                    s_done <= 1'b1; s_run <= 1'b0; {s_rh, s_rl} <= fact(s_operand);
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
            if (m_sel && m_wr) begin
                case (m_addr)
                    16'h0000: if (m_dout[0]) begin
                        if (cur_delay == 0) begin
                            s_done <= 1'b1; s_run <= 1'b0; {s_rh, s_rl} <= fact(s_operand);
                        end else begin
                            s_done <= 1'b0; s_run <= 1'b1; s_cnt <= cur_delay;
                        end
                    end
                    16'h0008: if (m_dout[0]) begin s_done <= 1'b0; s_run <= 1'b0; end
                    16'h0018: s_ien <= m_dout;
                    16'h0020: s_operand <= m_dout;
                    default: ;
                endcase
            end
            if (m_sel && !m_wr)
                m_din <= (m_addr == 16'h0028) ? s_rh :
                         (m_addr == 16'h0030) ? s_rl :
                         (m_addr == 16'h0010) ? {63'd0, s_done} : 64'd0;
        end
    end
    assign interrupt = s_ien[0] & s_done;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: job-level view of the scheduler.
    logic         m_active = 1'b0;
    logic         m_last = 1'b1;
    int           m_wait = 0;
    logic [1:0]   m_exp_ready = 2'b00;
    logic         m_exp_id = 1'b0;
    logic         m_exp_err = 1'b0;
    logic [127:0] m_exp_res = '0;
    bus_t         busq[$];

    // Stimulus state and observation logs.
    logic [63:0]  jq0[$], jq1[$];
    logic [1:0]   pend = 2'b00;
    logic [63:0]  op0 = '0, op1 = '0;
    int           force_delay = -1;
    int           hold = 0;
    bit           rr_rand = 0;
    bit           noise_en = 0;
    int           rand_jobs = 0;
    int           cyc = 0, ready_cyc = 0, rsp_cyc = 0, rv_count = 0;
    logic         prev_rv = 1'b0;
    bus_t         bus_log[$];
    int           grant_log[$];
    logic [127:0] res_log[$];
    logic         id_log[$], err_log[$];

    task automatic clear_logs();
        bus_log.delete(); grant_log.delete(); res_log.delete(); id_log.delete(); err_log.delete();
        rv_count = 0;
    endtask

    task automatic step();
        logic        rv_exp, hs;
        bus_t        b, e;
        int          g, d;
        logic [63:0] opnd;
        @(negedge clk);
        cyc++;
        rv_exp = m_active && (m_wait == 0);
        check("req_ready", 128'(req_ready), 128'(m_exp_ready));
        check("busy", 128'(busy), 128'(m_active));
        check("rsp_valid", 128'(rsp_valid), 128'(rv_exp));
        if (rv_exp) begin
            check("rsp_id", 128'(rsp_id), 128'(m_exp_id));
            check("rsp_result", rsp_result, m_exp_res);
            check("rsp_err", 128'(rsp_err), 128'(m_exp_err));
        end
        if (m_sel) begin
            b = {m_wr, m_addr, m_dout};
            bus_log.push_back(b);
            n_vec++;
            if (busq.size() == 0) begin
                n_err++;
                $display("FAIL bus_extra: access wr=%0d addr=%0h, expected none", m_wr, m_addr);
            end else begin
                e = busq.pop_front();
                check("bus_wr", 128'(m_wr), 128'(e.wr));
                check("bus_addr", 128'(m_addr), 128'(e.addr));
                if (e.wr) check("bus_data", 128'(m_dout), 128'(e.data));
            end
        end
        if (req_ready != 2'b00) ready_cyc = cyc;
        if (rsp_valid && !prev_rv) rsp_cyc = cyc;
        if (rsp_valid) rv_count++;
        prev_rv = rsp_valid;

        // Requesters: drop an accepted job, then offer the next one.
        if (req_ready[0]) pend[0] = 1'b0;
        if (req_ready[1]) pend[1] = 1'b0;
        if (rand_jobs > 0 && !pend[0] && jq0.size() == 0 && $urandom_range(0, 5) == 0) begin
            jq0.push_back(64'($urandom_range(0, 30))); rand_jobs--;
        end
        if (rand_jobs > 0 && !pend[1] && jq1.size() == 0 && $urandom_range(0, 5) == 0) begin
            jq1.push_back(64'($urandom_range(0, 30))); rand_jobs--;
        end
        if (!pend[0] && jq0.size() > 0) begin pend[0] = 1'b1; op0 = jq0.pop_front(); end
        if (!pend[1] && jq1.size() > 0) begin pend[1] = 1'b1; op1 = jq1.pop_front(); end

        if (hold > 0 && rv_exp) begin
            rsp_ready = 1'b0; hold--;
        end else begin
            rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        hs = rv_exp && rsp_ready;
        if (noise_en && m_active && !hs && $urandom_range(0, 1) == 1) begin
            req_valid   = 2'($urandom_range(0, 3));
            req_operand = {64'($urandom), 64'($urandom)};
        end else begin
            req_valid   = pend;
            req_operand = {op1, op0};
        end

        m_exp_ready = 2'b00;
        if (!m_active) begin
            if (req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? int'(!m_last) : (req_valid[1] ? 1 : 0);
                m_exp_ready = (g == 1) ? 2'b10 : 2'b01;
                m_last = 1'(g);
                m_active = 1'b1;
                opnd = (g == 1) ? req_operand[127:64] : req_operand[63:0];
                d = (force_delay >= 0) ? force_delay : $urandom_range(0, 19);
                cur_delay = d;
                m_exp_id = 1'(g);
                m_exp_err = (d >= T);
                m_exp_res = (d >= T) ? 128'd0 : fact(opnd);
                m_wait = (d >= T) ? 5 + T : 10 + d;
                busq.push_back({1'b1, 16'h0020, opnd});
                busq.push_back({1'b1, 16'h0018, 64'd1});
                busq.push_back({1'b1, 16'h0000, 64'd1});
                if (d < T) begin
                    busq.push_back({1'b0, 16'h0028, 64'd0});
                    busq.push_back({1'b0, 16'h0030, 64'd0});
                end
                busq.push_back({1'b1, 16'h0008, 64'd1});
                busq.push_back({1'b1, 16'h0008, 64'd0});
                grant_log.push_back(g);
            end
        end else if (hs) begin
            check("bus_all_done", 128'(busq.size()), 128'd0);
            res_log.push_back(rsp_result);
            id_log.push_back(rsp_id);
            err_log.push_back(rsp_err);
            m_active = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
        end
    endtask

    task automatic do_reset(input int ncyc);
        reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
            check("rst_req_ready", 128'(req_ready), 128'd0);
            check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
            check("rst_rsp_id", 128'(rsp_id), 128'd0);
            check("rst_rsp_result", rsp_result, 128'd0);
            check("rst_rsp_err", 128'(rsp_err), 128'd0);
            check("rst_busy", 128'(busy), 128'd0);
            check("rst_m_sel", 128'(m_sel), 128'd0);
            check("rst_m_wr", 128'(m_wr), 128'd0);
            check("rst_m_addr", 128'(m_addr), 128'd0);
            check("rst_m_dout", 128'(m_dout), 128'd0);
        end
        m_active = 1'b0; m_last = 1'b1; m_wait = 0; m_exp_ready = 2'b00;
        busq.delete(); jq0.delete(); jq1.delete(); pend = 2'b00; hold = 0; prev_rv = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((m_active || pend != 2'b00 || jq0.size() > 0 || jq1.size() > 0 || rand_jobs > 0)
               && k < budget) begin
            step();
            k++;
        end
        n_vec++;
        if (k >= budget) begin
            n_err++;
            $display("FAIL run_budget: %0d cycles used, limit %0d", k, budget);
        end
        step();
    endtask

    task automatic check_bus(input int i, input logic wr, input logic [15:0] addr,
                             input logic [63:0] data);
        if (i >= bus_log.size()) begin
            n_vec++; n_err++;
            $display("FAIL trace_len: entry %0d missing, log has %0d", i, bus_log.size());
        end else begin
            check("trace_wr", 128'(bus_log[i].wr), 128'(wr));
            check("trace_addr", 128'(bus_log[i].addr), 128'(addr));
            if (wr) check("trace_data", 128'(bus_log[i].data), 128'(data));
        end
    endtask

    initial begin
        do_reset(3);

        // Single job, operand 5, interrupt 3 cycles after start.
        clear_logs(); force_delay = 3; jq0.push_back(64'd5);
        run_until_idle(200);
        check("job5_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd120);
        check("job5_id", 128'(id_log.size() > 0 ? id_log[0] : 1'bx), 128'd0);
        check("job5_err", 128'(err_log.size() > 0 ? err_log[0] : 1'bx), 128'd0);
        check("job5_latency", 128'(rsp_cyc - ready_cyc + 1), 128'd14);
        check("trace_len", 128'(bus_log.size()), 128'd7);
        check_bus(0, 1'b1, 16'h0020, 64'd5);
        check_bus(1, 1'b1, 16'h0018, 64'd1);
        check_bus(2, 1'b1, 16'h0000, 64'd1);
        check_bus(3, 1'b0, 16'h0028, 64'd0);
        check_bus(4, 1'b0, 16'h0030, 64'd0);
        check_bus(5, 1'b1, 16'h0008, 64'd1);
        check_bus(6, 1'b1, 16'h0008, 64'd0);

        // Both requesters continuously valid after reset.
        do_reset(1);
        clear_logs(); force_delay = 2;
        jq0.push_back(64'd3); jq0.push_back(64'd3); jq1.push_back(64'd4); jq1.push_back(64'd4);
        run_until_idle(300);
        check("rr_count", 128'(grant_log.size()), 128'd4);
        for (int i = 0; i < 4 && i < grant_log.size() && i < res_log.size(); i++) begin
            check("rr_grant", 128'(grant_log[i]), 128'(i % 2));
            check("rr_result", res_log[i], (i % 2 == 0) ? 128'd6 : 128'd24);
        end

        // Operand 20 with interrupt already high, then operand 0.
        clear_logs(); force_delay = 0; jq1.push_back(64'd20);
        run_until_idle(200);
        check("op20_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd2432902008176640000);
        check("op20_latency", 128'(rsp_cyc - ready_cyc + 1), 128'd11);
        clear_logs(); force_delay = 1; jq0.push_back(64'd0);
        run_until_idle(200);
        check("op0_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd1);

        // Timeout: interrupt never rises.
        clear_logs(); force_delay = NEVER; jq1.push_back(64'd7);
        run_until_idle(200);
        check("tmo_err", 128'(err_log.size() > 0 ? err_log[0] : 1'bx), 128'd1);
        check("tmo_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd0);
        check("tmo_latency", 128'(rsp_cyc - ready_cyc), 128'd21);
        check("tmo_trace_len", 128'(bus_log.size()), 128'd5);
        check_bus(3, 1'b1, 16'h0008, 64'd1);
        check_bus(4, 1'b1, 16'h0008, 64'd0);

        // Timeout boundary: irq on the last allowed cycle, then one cycle late.
        clear_logs(); force_delay = T - 1; jq0.push_back(64'd6);
        run_until_idle(200);
        check("edge15_err", 128'(err_log.size() > 0 ? err_log[0] : 1'bx), 128'd0);
        check("edge15_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd720);
        clear_logs(); force_delay = T; jq0.push_back(64'd6);
        run_until_idle(200);
        check("edge16_err", 128'(err_log.size() > 0 ? err_log[0] : 1'bx), 128'd1);

        // Response back-pressure for 5 cycles.
        clear_logs(); force_delay = 0; hold = 5; jq1.push_back(64'd4);
        run_until_idle(200);
        check("bp_valid_cycles", 128'(rv_count), 128'd6);
        check("bp_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd24);

        // Reset while waiting for the interrupt, then a fresh job.
        force_delay = NEVER; jq0.push_back(64'd9);
        for (int i = 0; i < 8; i++) step();
        do_reset(2);
        clear_logs(); force_delay = 1; jq1.push_back(64'd3); jq0.push_back(64'd5);
        run_until_idle(300);
        check("post_rst_first_grant", 128'(grant_log.size() > 0 ? grant_log[0] : -1), 128'd0);
        check("post_rst_result", res_log.size() > 0 ? res_log[0] : 128'hx, 128'd120);

        // Randomized jobs with noisy inputs while busy and random back-pressure.
        force_delay = -1; rr_rand = 1; noise_en = 1; rand_jobs = 150;
        run_until_idle(40000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
